// File: rtl/cpu_run_ctl_pkg.sv
// Shared types for the CPU run/step controller.
// Opcodes, FSM states and stop causes.
package cpu_run_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_RUN   = 3'd1,
        OP_STEP  = 3'd2,
        OP_RUN_N = 3'd3,
        OP_STOP  = 3'd4,
        OP_RESET = 3'd5
    } op_t;

    typedef enum logic [2:0] {
        S_CPURST = 3'd0,
        S_IDLE   = 3'd1,
        S_RUN    = 3'd2,
        S_RUN_N  = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        C_NONE  = 3'd0,
        C_BRK   = 3'd1,
        C_HLT   = 3'd2,
        C_HOST  = 3'd3,
        C_COUNT = 3'd4,
        C_RESET = 3'd5
    } cause_t;

    // Opcodes that try to start execution.
    function automatic logic is_start_op(input logic [OP_W-1:0] op);
        return (op == OP_RUN) || (op == OP_STEP) || (op == OP_RUN_N);
    endfunction

    // Opcodes 6 and 7 are not defined.
    function automatic logic is_bad_op(input logic [OP_W-1:0] op);
        return op[2] && op[1];
    endfunction

endpackage

// File: rtl/cpu_run_ctl_if.sv
// Host command channel for the run controller.
// Valid/ready handshake carrying opcode and run count.
interface cpu_run_ctl_if #(
    parameter int CNT_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_count,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_count,
        output cmd_ready
    );
endinterface

// File: rtl/cpu_run_ctl.sv
// Run/step scheduler for the 8-bit CPU core.
// Gates CPU cycles, sequences CPU reset, stops on brk/hlt.
module cpu_run_ctl
    import cpu_run_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int RST_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    cpu_run_ctl_if.slave cmd,
    input  logic        brk,
    input  logic        hlt,
    output logic        cpu_clk_en,
    output logic        cpu_rst,
    output logic        ctrlen,
    output state_t      state,
    output cause_t      stop_cause,
    output logic        cmd_err,
    output logic [31:0] cycle_cnt
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] count;
    logic [RC_W-1:0]  rst_cnt;
    logic             brk_skip;

    logic running;
    logic acc;
    logic op_run;
    logic op_step;
    logic op_run_n;
    logic op_stop;
    logic op_reset;
    logic op_start;
    logic op_bad;
    logic brk_stop;

    // Decode handshake, command and cycle gate from registered state.
    always_comb begin
        running       = (state == S_RUN) || (state == S_RUN_N);
        cmd.cmd_ready = (state != S_CPURST);
        acc           = cmd.cmd_valid && cmd.cmd_ready;
        op_run        = acc && (cmd.cmd_op == OP_RUN);
        op_step       = acc && (cmd.cmd_op == OP_STEP);
        op_run_n      = acc && (cmd.cmd_op == OP_RUN_N);
        op_stop       = acc && (cmd.cmd_op == OP_STOP);
        op_reset      = acc && (cmd.cmd_op == OP_RESET);
        op_start      = acc && is_start_op(cmd.cmd_op);
        op_bad        = acc && is_bad_op(cmd.cmd_op);
        brk_stop      = brk && !brk_skip;
        cpu_clk_en    = running && !hlt && !brk_stop;
    end

    // Controller FSM with run counter, reset pulse and cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_CPURST;
            stop_cause <= C_RESET;
            cpu_rst    <= 1'b1;
            ctrlen     <= 1'b0;
            cmd_err    <= 1'b0;
            cycle_cnt  <= '0;
            count      <= '0;
            rst_cnt    <= '0;
            brk_skip   <= 1'b0;
        end else begin
            cmd_err <= op_bad || (op_start && (state != S_IDLE));

            if (cpu_clk_en) begin
                cycle_cnt <= cycle_cnt + 32'd1;
                brk_skip  <= 1'b0;
                if (state == S_RUN_N) begin
                    count <= count - CNT_ONE;
                end
            end

            unique case (state)
                S_CPURST: begin
                    cycle_cnt <= '0;
                    if (rst_cnt == RC_LAST) begin
                        state   <= S_IDLE;
                        cpu_rst <= 1'b0;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (op_run) begin
                        state      <= S_RUN;
                        ctrlen     <= 1'b1;
                        stop_cause <= C_NONE;
                        brk_skip   <= 1'b1;
                    end else if (op_step) begin
                        state      <= S_RUN_N;
                        ctrlen     <= 1'b1;
                        count      <= CNT_ONE;
                        stop_cause <= C_NONE;
                        brk_skip   <= 1'b1;
                    end else if (op_run_n) begin
                        if (cmd.cmd_count == '0) begin
                            stop_cause <= C_COUNT;
                        end else begin
                            state      <= S_RUN_N;
                            ctrlen     <= 1'b1;
                            count      <= cmd.cmd_count;
                            stop_cause <= C_NONE;
                            brk_skip   <= 1'b1;
                        end
                    end
                end
                S_RUN, S_RUN_N: begin
                    if (hlt) begin
                        state      <= S_HALTED;
                        ctrlen     <= 1'b0;
                        stop_cause <= C_HLT;
                    end else if (brk_stop) begin
                        state      <= S_IDLE;
                        ctrlen     <= 1'b0;
                        stop_cause <= C_BRK;
                    end else if (op_stop) begin
                        state      <= S_IDLE;
                        ctrlen     <= 1'b0;
                        stop_cause <= C_HOST;
                    end else if ((state == S_RUN_N) && (count == CNT_ONE)) begin
                        state      <= S_IDLE;
                        ctrlen     <= 1'b0;
                        stop_cause <= C_COUNT;
                    end
                end
                S_HALTED: begin
                end
                default: begin
                    state <= S_CPURST;
                end
            endcase

            // Host reset overrides everything, including an issued cycle.
            if (op_reset) begin
                state      <= S_CPURST;
                stop_cause <= C_RESET;
                cpu_rst    <= 1'b1;
                ctrlen     <= 1'b0;
                cycle_cnt  <= '0;
                count      <= '0;
                rst_cnt    <= '0;
                brk_skip   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cpu_run_ctl.sv
// Self-checking bench for cpu_run_ctl.
// Directed scenarios plus random traffic against a behavioural model.
module tb_cpu_run_ctl;
    import cpu_run_pkg::*;

    localparam int CNT_W      = 16;
    localparam int RST_CYCLES = 4;

    logic clk = 1'b0;
    logic rst;
    logic brk;
    logic hlt;
    logic cpu_clk_en;
    logic cpu_rst;
    logic ctrlen;
    logic cmd_err;
    state_t state;
    cause_t stop_cause;
    logic [31:0] cycle_cnt;

    always #5 clk = ~clk;

    cpu_run_ctl_if #(.CNT_W(CNT_W)) cif ();

    cpu_run_ctl #(
        .CNT_W(CNT_W),
        .RST_CYCLES(RST_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd(cif),
        .brk(brk),
        .hlt(hlt),
        .cpu_clk_en(cpu_clk_en),
        .cpu_rst(cpu_rst),
        .ctrlen(ctrlen),
        .state(state),
        .stop_cause(stop_cause),
        .cmd_err(cmd_err),
        .cycle_cnt(cycle_cnt)
    );

    int total = 0;
    int bad = 0;
    int fail_prints = 0;
    int pulses = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (fail_prints < 40)
                $display("FAIL %s: got %0d want %0d at %0t",
                         name, act, exp, $time);
            fail_prints++;
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_on = 1'b0;
    state_t      m_st;
    cause_t      m_cause;
    bit          m_err;
    logic [31:0] m_cyc;
    int          m_left;
    bit          m_skip;
    int          m_rleft;

    function automatic bit m_running();
        return (m_st == S_RUN) || (m_st == S_RUN_N);
    endfunction

    function automatic bit m_en();
        return m_running() && !hlt && !(brk && !m_skip);
    endfunction

    task automatic model_step();
        bit acc;
        bit issue;
        bit start;
        int op;
        int n;
        int k;
        if (rst) begin
            m_on    = 1'b1;
            m_st    = S_CPURST;
            m_rleft = RST_CYCLES;
            m_cause = C_RESET;
            m_err   = 1'b0;
            m_cyc   = 0;
            m_left  = 0;
            m_skip  = 1'b0;
        end else if (m_on) begin
            acc   = cif.cmd_valid && (m_st != S_CPURST);
            op    = int'(cif.cmd_op);
            n     = int'(cif.cmd_count);
            issue = m_en();
            start = acc && (op >= 1) && (op <= 3);
            m_err = acc && ((op >= 6) || (start && m_st != S_IDLE));
            if (acc && op == 5) begin
                m_st    = S_CPURST;
                m_rleft = RST_CYCLES;
                m_cause = C_RESET;
                m_cyc   = 0;
                m_left  = 0;
                m_skip  = 1'b0;
            end else if (m_st == S_CPURST) begin
                m_rleft--;
                if (m_rleft == 0) m_st = S_IDLE;
            end else if (m_st == S_IDLE) begin
                if (start && op == 1) begin
                    m_st    = S_RUN;
                    m_cause = C_NONE;
                    m_skip  = 1'b1;
                end else if (start) begin
                    k = (op == 2) ? 1 : n;
                    if (k == 0) begin
                        m_cause = C_COUNT;
                    end else begin
                        m_st    = S_RUN_N;
                        m_left  = k;
                        m_cause = C_NONE;
                        m_skip  = 1'b1;
                    end
                end
            end else if (m_running()) begin
                if (issue) begin
                    m_cyc  = m_cyc + 1;
                    m_skip = 1'b0;
                    if (m_st == S_RUN_N) m_left--;
                end
                if (hlt) begin
                    m_st    = S_HALTED;
                    m_cause = C_HLT;
                end else if (!issue) begin
                    m_st    = S_IDLE;
                    m_cause = C_BRK;
                end else if (acc && op == 4) begin
                    m_st    = S_IDLE;
                    m_cause = C_HOST;
                end else if (m_st == S_RUN_N && m_left == 0) begin
                    m_st    = S_IDLE;
                    m_cause = C_COUNT;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Compare every cycle once the model is initialised.
    initial begin
        forever begin
            @(negedge clk);
            if (cpu_clk_en === 1'b1) pulses++;
            if (m_on) begin
                chk("state", state, m_st);
                chk("stop_cause", stop_cause, m_cause);
                chk("cpu_rst", cpu_rst, m_st == S_CPURST);
                chk("ctrlen", ctrlen, m_running());
                chk("cmd_err", cmd_err, m_err);
                chk("cycle_cnt", cycle_cnt, m_cyc);
                chk("cmd_ready", cif.cmd_ready, m_st != S_CPURST);
                chk("cpu_clk_en", cpu_clk_en, m_en());
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input int n,
                        output logic en_seen);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        cif.cmd_count = CNT_W'(n);
        @(negedge clk);
        en_seen = cpu_clk_en;
        chk("ready_at_cmd", cif.cmd_ready, 1);
        @(posedge clk);
        #1;
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = 3'd0;
        cif.cmd_count = '0;
    endtask

    task automatic cnt_rst(output int c);
        bit done;
        c = 0;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            if (cpu_rst) c++;
            else done = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        logic e;
        int c;
        send(3'd5, 0, e);
        cnt_rst(c);
        chk("cmd_reset_len", c, RST_CYCLES);
        chk("cmd_reset_cyc", cycle_cnt, 0);
        chk("cmd_reset_state", state, S_IDLE);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic e;
        int c;
        int p0;
        rst = 1'b1;
        brk = 1'b0;
        hlt = 1'b0;
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = 3'd0;
        cif.cmd_count = '0;
        tick(3);
        rst = 1'b0;

        cnt_rst(c);
        chk("rst_pulse_len", c, 4);
        chk("rst_state", state, S_IDLE);
        chk("rst_ready", cif.cmd_ready, 1);
        chk("rst_cause", stop_cause, C_RESET);
        chk("rst_cyc", cycle_cnt, 0);

        p0 = pulses;
        send(3'd3, 5, e);
        tick(10);
        chk("runn5_pulses", pulses - p0, 5);
        chk("runn5_state", state, S_IDLE);
        chk("runn5_cause", stop_cause, C_COUNT);
        chk("runn5_cyc", cycle_cnt, 5);

        do_reset();
        send(3'd1, 0, e);
        tick(3);
        brk = 1'b1;
        tick(3);
        chk("brk_state", state, S_IDLE);
        chk("brk_cause", stop_cause, C_BRK);
        chk("brk_cyc", cycle_cnt, 3);
        p0 = pulses;
        send(3'd2, 0, e);
        tick(3);
        chk("step_pulses", pulses - p0, 1);
        chk("step_cyc", cycle_cnt, 4);
        chk("step_cause", stop_cause, C_COUNT);
        brk = 1'b0;

        do_reset();
        send(3'd1, 0, e);
        tick(7);
        hlt = 1'b1;
        tick(2);
        chk("hlt_state", state, S_HALTED);
        chk("hlt_cause", stop_cause, C_HLT);
        chk("hlt_cyc", cycle_cnt, 7);
        send(3'd1, 0, e);
        chk("hlt_run_err", cmd_err, 1);
        chk("hlt_run_state", state, S_HALTED);
        hlt = 1'b0;
        do_reset();

        send(3'd1, 0, e);
        tick(2);
        brk = 1'b1;
        send(3'd4, 0, e);
        chk("stopbrk_pulse", e, 0);
        chk("stopbrk_cause", stop_cause, C_BRK);
        chk("stopbrk_cyc", cycle_cnt, 2);
        brk = 1'b0;
        send(3'd1, 0, e);
        tick(2);
        send(3'd4, 0, e);
        chk("stophost_pulse", e, 1);
        chk("stophost_cause", stop_cause, C_HOST);
        chk("stophost_state", state, S_IDLE);
        chk("stophost_cyc", cycle_cnt, 5);

        p0 = pulses;
        send(3'd3, 0, e);
        tick(2);
        chk("runn0_pulses", pulses - p0, 0);
        chk("runn0_cause", stop_cause, C_COUNT);
        chk("runn0_state", state, S_IDLE);
        send(3'd7, 0, e);
        chk("op7_err", cmd_err, 1);
        chk("op7_state", state, S_IDLE);
        tick(1);
        chk("op7_err_clear", cmd_err, 0);

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            brk = ($urandom_range(0, 9) == 0);
            hlt = ($urandom_range(0, 39) == 0);
            cif.cmd_valid = ($urandom_range(0, 3) == 0);
            cif.cmd_op    = 3'($urandom_range(0, 7));
            cif.cmd_count = CNT_W'($urandom_range(0, 6));
            tick(1);
        end
        rst = 1'b0;
        brk = 1'b0;
        hlt = 1'b0;
        cif.cmd_valid = 1'b0;
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctl.md
Name: cpu_run_ctl

Overview:
Run/step scheduler for the 8-bit CPU core. It gates CPU clock cycles with a one-cycle-per-clk enable and sequences the CPU reset pulse. It stops on the CPU's brk/hlt outputs and accepts host commands (run, step, run-N, stop, reset) over a valid/ready handshake. While the CPU is stopped it releases ctrlen, so the host/emulator can own main_bus and addr_bus.

Parameters:
CNT_W, 16, width of the run-N cycle count
RST_CYCLES, 4, length of the cpu_rst pulse in clk cycles (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  controller can accept a command
cmd_op  in  3  command opcode (cpu_run_pkg::op_t)
cmd_count  in  CNT_W  cycle count for OP_RUN_N
brk  in  1  CPU breakpoint bit of the current control word
hlt  in  1  CPU halt bit of the current control word
cpu_clk_en  out  1  execute one CPU cycle this clk
cpu_rst  out  1  CPU reset, active-high
ctrlen  out  1  CPU control-word drive enable
state  out  3  current FSM state (state_t)
stop_cause  out  3  reason for the last stop (cause_t)
cmd_err  out  1  1-cycle pulse: accepted command was ignored
cycle_cnt  out  32  CPU cycles issued since last CPU reset, wraps at 2^32

Behaviour:
- Opcodes: OP_NOP=0, OP_RUN=1, OP_STEP=2, OP_RUN_N=3, OP_STOP=4, OP_RESET=5. Values 6–7 are accepted, do nothing, and pulse cmd_err.
- States: S_CPURST, S_IDLE, S_RUN, S_RUN_N, S_HALTED.
- Causes: C_NONE, C_BRK, C_HLT, C_HOST, C_COUNT, C_RESET.
- rst: state=S_CPURST, cpu_rst=1, cpu_clk_en=0, ctrlen=0, cmd_ready=0, cmd_err=0, stop_cause=C_RESET, cycle_cnt=0, internal count=0, brk_skip=0.
- S_CPURST:
  - cpu_rst=1 for exactly RST_CYCLES clks, then S_IDLE.
  - cycle_cnt held at 0; cmd_ready=0.
- cmd_ready=1 in every state except S_CPURST. A command is accepted on cmd_valid&&cmd_ready.
- S_IDLE:
  - OP_RUN -> S_RUN. OP_STEP -> S_RUN_N with count=1. OP_RUN_N -> S_RUN_N with count=cmd_count. On each of these, stop_cause:=C_NONE and brk_skip:=1.
  - OP_RUN_N with cmd_count=0: stay in S_IDLE, stop_cause:=C_COUNT, no cycle issued.
  - OP_STOP and OP_NOP: no effect.
- S_RUN and S_RUN_N:
  - ctrlen=1.
  - cpu_clk_en = !hlt && !(brk && !brk_skip) (combinational from registered state and brk/hlt).
  - Each issued cycle: cycle_cnt+=1, brk_skip:=0; in S_RUN_N also count-=1.
  - Stop checks are evaluated in priority order; the first that applies decides the next state:
    1. OP_RESET accepted -> S_CPURST, cause C_RESET.
    2. hlt=1 -> S_HALTED, cause C_HLT, no cycle issued.
    3. brk=1 and brk_skip=0 -> S_IDLE, cause C_BRK, no cycle issued.
    4. OP_STOP accepted -> S_IDLE, cause C_HOST. The cycle in the same clk is still issued.
    5. S_RUN_N with count==1 and a cycle issued -> S_IDLE, cause C_COUNT.
  - OP_RUN, OP_STEP and OP_RUN_N while running: accepted, ignored, cmd_err pulse.
- S_IDLE and S_HALTED: ctrlen=0, cpu_clk_en=0.
- S_HALTED: only OP_RESET has an effect. OP_RUN, OP_STEP and OP_RUN_N pulse cmd_err. OP_STOP and OP_NOP have no effect.
- OP_RESET from any accepting state: S_CPURST on the next clk, cycle_cnt:=0, any count in flight is discarded.
- brk_skip lets a resume execute past the breakpoint that caused the stop. It clears after the first issued cycle.
- cycle_cnt wraps from 0xFFFFFFFF to 0 with no flag.
- Outputs state, stop_cause, cpu_rst, ctrlen, cmd_err and cycle_cnt are registered. cpu_clk_en and cmd_ready are decoded from registered state plus brk/hlt.

Decomposition:
- Package cpu_run_pkg holds:
  - op_t enum (3 bits)
  - state_t enum (3 bits)
  - cause_t enum (3 bits)
  - opcode constants
- No sub-module. The FSM, run counter, reset-pulse counter and cycle counter live in one module.

Test Plan:
- Reset, RST_CYCLES=4 -> cpu_rst high exactly 4 clks; then state=S_IDLE, cmd_ready=1, stop_cause=C_RESET, cycle_cnt=0.
- OP_RUN_N with cmd_count=5, brk=hlt=0 -> exactly 5 consecutive cpu_clk_en pulses; then S_IDLE, C_COUNT, cycle_cnt=5, ctrlen falls the clk after the last pulse.
- OP_RUN, brk raised after 3 cycles -> stop with no 4th pulse, C_BRK, cycle_cnt=3. Then OP_STEP with brk still 1 -> exactly 1 pulse, cycle_cnt=4, C_COUNT.
- OP_RUN, hlt=1 at cycle 7 -> S_HALTED, C_HLT, cycle_cnt=7. OP_RUN -> cmd_err pulse, state unchanged. OP_RESET -> 4-clk cpu_rst, cycle_cnt=0.
- OP_RUN, OP_STOP and brk=1 in the same clk -> cause C_BRK, no pulse that clk. Repeat with brk=0 -> C_HOST, that clk's pulse is issued.
- OP_RUN_N with cmd_count=0 -> no pulse, C_COUNT, stays S_IDLE. cmd_op=7 -> cmd_err pulse only.
